// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: tracks pending register writers, stalls decode
// on RAW/WAW/in-flight-limit hazards and flushes decode after a redirect.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic [4:0]  dec_rd,
  input  logic        dec_rd_wr,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        redirect,
  output logic        issue,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        flush_decode,
  output logic [31:0] pending,
  output logic [15:0] stall_count,
  output logic        wb_err
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t         state_reg, state_next;
  logic [3:0]     flush_cnt_reg, flush_cnt_next;
  logic [31:0]    pending_reg;
  logic [IW-1:0]  inflight_reg, inflight_next;
  logic [15:0]    stall_count_reg;
  logic           wb_err_reg;

  logic           wb_hit;
  logic           wb_miss;
  logic           src1_haz, src2_haz, dst_haz, full_haz;
  logic           hazard;
  logic           in_flush;
  logic           stall_int;
  logic           do_set;
  logic [31:0]    set_mask;
  logic [31:0]    clr_mask;

  // A writeback only retires a writer when that register is really pending;
  // x0 writebacks are ignored entirely.
  assign wb_hit  = wb_valid && (wb_rd != 5'd0) && pending_reg[wb_rd];
  assign wb_miss = wb_valid && (wb_rd != 5'd0) && !pending_reg[wb_rd];

  // Same-cycle writeback of a source/destination resolves the hazard (bypass).
  assign src1_haz = dec_rs1_used && (dec_rs1 != 5'd0) && pending_reg[dec_rs1]
                    && !(wb_valid && (wb_rd == dec_rs1));
  assign src2_haz = dec_rs2_used && (dec_rs2 != 5'd0) && pending_reg[dec_rs2]
                    && !(wb_valid && (wb_rd == dec_rs2));
  assign dst_haz  = dec_rd_wr && (dec_rd != 5'd0) && pending_reg[dec_rd]
                    && !(wb_valid && (wb_rd == dec_rd));
  assign full_haz = (inflight_reg == IW'(MAX_INFLIGHT)) && !wb_hit;

  assign hazard   = dec_valid && (src1_haz || src2_haz || dst_haz || full_haz);
  assign in_flush = (state_reg == FLUSH);

  // Control outputs are combinational; everything is held low during reset.
  assign issue        = rst_n && dec_valid && !hazard && !redirect && !in_flush;
  assign stall_int    = rst_n && dec_valid && hazard && !redirect && !in_flush;
  assign stall_decode = stall_int;
  assign stall_fetch  = stall_int;
  assign flush_decode = rst_n && (redirect || in_flush);

  assign do_set = issue && dec_rd_wr && (dec_rd != 5'd0);

  // Per-register scoreboard bit; a set in the same cycle as a clear wins.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      assign set_mask[gi] = do_set && (dec_rd == 5'(gi));
      assign clr_mask[gi] = wb_hit && (wb_rd == 5'(gi));

      // Scoreboard bit update
      always_ff @(posedge clk) begin
        if (!rst_n)
          pending_reg[gi] <= 1'b0;
        else if (set_mask[gi])
          pending_reg[gi] <= 1'b1;
        else if (clr_mask[gi])
          pending_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  // In-flight writer count: set and retire in one cycle cancel out.
  always_comb begin
    inflight_next = inflight_reg;
    case ({do_set, wb_hit})
      2'b10:   inflight_next = inflight_reg + IW'(1);
      2'b01:   inflight_next = inflight_reg - IW'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  // Next-state logic: redirect dominates from any state.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    if (redirect) begin
      state_next     = FLUSH;
      flush_cnt_next = 4'(FLUSH_CYCLES - 1);
    end else begin
      case (state_reg)
        RUN:     if (stall_int) state_next = STALL;
        STALL:   if (!stall_int) state_next = RUN;
        FLUSH: begin
          if (flush_cnt_reg == 4'd0)
            state_next = RUN;
          else
            flush_cnt_next = flush_cnt_reg - 4'd1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State, counters and sticky error register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      flush_cnt_reg   <= 4'd0;
      inflight_reg    <= '0;
      stall_count_reg <= 16'd0;
      wb_err_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      inflight_reg  <= inflight_next;
      if (stall_int && (stall_count_reg != 16'hFFFF))
        stall_count_reg <= stall_count_reg + 16'd1;
      if (wb_miss)
        wb_err_reg <= 1'b1;
    end
  end

  assign pending     = pending_reg;
  assign stall_count = stall_count_reg;
  assign wb_err      = wb_err_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver computes expected per-cycle response from a
// behavioural model and queues it; monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int FC  = 2;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        dec_rs1_used, dec_rs2_used, dec_rd_wr, wb_valid, redirect;
  logic        issue, stall_fetch, stall_decode, flush_decode, wb_err;
  logic [31:0] pending;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .redirect(redirect),
    .issue(issue), .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_decode(flush_decode), .pending(pending),
    .stall_count(stall_count), .wb_err(wb_err)
  );

  typedef struct packed {
    logic        iss;
    logic        sf;
    logic        sd;
    logic        fl;
    logic [31:0] pend;
    logic [15:0] sc;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  // Reference model: set of waiting registers, flush cycles left, counters.
  bit m_pend[32];
  int m_flush_left = 0;
  int m_stalls     = 0;
  bit m_err        = 0;

  function automatic int waiting_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_pend[i];
    return c;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expected response, advance the model.
  task automatic step(input bit rn, input bit dv, input int rs1, input bit u1,
                      input int rs2, input bit u2, input int rd, input bit rdw,
                      input bit wv, input int wrd, input bit rdr, input bit log);
    bit   wb_retires, blocked, flushing, iss, stl;
    exp_t e;
    @(negedge clk);
    rst_n = rn; dec_valid = dv; dec_rs1 = 5'(rs1); dec_rs1_used = u1;
    dec_rs2 = 5'(rs2); dec_rs2_used = u2; dec_rd = 5'(rd); dec_rd_wr = rdw;
    wb_valid = wv; wb_rd = 5'(wrd); redirect = rdr;

    wb_retires = wv && wrd != 0 && m_pend[wrd];
    blocked = 0;
    if (u1 && rs1 != 0 && m_pend[rs1] && !(wv && wrd == rs1)) blocked = 1;
    if (u2 && rs2 != 0 && m_pend[rs2] && !(wv && wrd == rs2)) blocked = 1;
    if (rdw && rd != 0 && m_pend[rd] && !(wv && wrd == rd)) blocked = 1;
    if (waiting_count() == MAX && !wb_retires) blocked = 1;
    flushing = (m_flush_left > 0);
    iss = rn && dv && !blocked && !rdr && !flushing;
    stl = rn && dv && blocked && !rdr && !flushing;

    e.iss = iss; e.sf = stl; e.sd = stl; e.fl = rn && (rdr || flushing);
    e.pend = pend_vec(); e.sc = 16'(m_stalls); e.err = m_err;
    if (log) q.push_back(e);

    if (!rn) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_flush_left = 0; m_stalls = 0; m_err = 0;
    end else begin
      if (wv && wrd != 0) begin
        if (m_pend[wrd]) m_pend[wrd] = 0;
        else m_err = 1;
      end
      if (iss && rdw && rd != 0) m_pend[rd] = 1;
      if (stl && m_stalls < 65535) m_stalls++;
      if (rdr) m_flush_left = FC;
      else if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  task automatic idle(input bit log);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, log);
  endtask

  task automatic do_reset();
    step(0, 1, 3, 1, 4, 1, 5, 1, 1, 5, 1, 1);
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_txn++;
        n_checks++;
        if ({issue, stall_fetch, stall_decode, flush_decode} === {e.iss, e.sf, e.sd, e.fl}) n_pass++;
        else $display("FAIL ctrl txn %0d: got iss/sf/sd/fl=%b%b%b%b expected %b%b%b%b", n_txn,
                      issue, stall_fetch, stall_decode, flush_decode, e.iss, e.sf, e.sd, e.fl);
        n_checks++;
        if (pending === e.pend) n_pass++;
        else $display("FAIL pending txn %0d: got %h expected %h", n_txn, pending, e.pend);
        n_checks++;
        if (stall_count === e.sc) n_pass++;
        else $display("FAIL stall_count txn %0d: got %0d expected %0d", n_txn, stall_count, e.sc);
        n_checks++;
        if (wb_err === e.err) n_pass++;
        else $display("FAIL wb_err txn %0d: got %b expected %b", n_txn, wb_err, e.err);
        $display("txn %0d: iss=%b stall=%b flush=%b pend=%h sc=%0d err=%b", n_txn,
                 issue, stall_decode, flush_decode, pending, stall_count, wb_err);
      end
    end
  end

  initial begin
    int cands[$];
    int wrd;
    rst_n = 0; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0;
    dec_rs2_used = 0; dec_rd = 0; dec_rd_wr = 0; wb_valid = 0; wb_rd = 0; redirect = 0;

    // Reset: first cycle state is unknown, so only log the second.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(1);

    // RAW on x5: stall until writeback, issue in the writeback cycle.
    step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
    repeat (3) step(1, 1, 5, 1, 0, 0, 8, 1, 0, 0, 0, 1);
    step(1, 1, 5, 1, 0, 0, 8, 1, 1, 5, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 1);

    // Redirect during stall: flush, no stall, scoreboard kept.
    step(1, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1);
    step(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) step(1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 1);

    // In-flight limit.
    for (int r = 1; r <= 4; r++) step(1, 1, 0, 0, 0, 0, r, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1);

    // x0 never stalls; writeback of a non-pending register flags an error.
    repeat (3) step(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1);
    idle(1);

    // Simultaneous issue and writeback of x7.
    step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 1);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1);

    // Reset in the middle of a flush.
    step(1, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    do_reset();
    step(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Randomized traffic biased toward small register numbers.
    for (int n = 0; n < 1500; n++) begin
      cands.delete();
      for (int i = 1; i < 32; i++) if (m_pend[i]) cands.push_back(i);
      if (cands.size() != 0 && ($urandom % 4) != 0) wrd = cands[$urandom % cands.size()];
      else wrd = int'($urandom % 8);
      step(($urandom % 100) != 0, ($urandom % 4) != 0,
           int'($urandom % 8), 1'($urandom), int'($urandom % 8), 1'($urandom),
           int'($urandom % 8), 1'($urandom), ($urandom % 2) == 0, wrd,
           ($urandom % 20) == 0, 1);
    end

    // Stall counter saturation.
    do_reset();
    step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++)
      step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, (i < 2) || (i > 65532));
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
    idle(1);

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d queued entries expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
